johnson_counter: RTL and testbench

- Parameterised W-bit Johnson (twisted-ring) counter with a parallel seed load and optional self-correction of illegal states.
- Free-runs through the 2*W-state Johnson sequence.
- A non-zero value on seq overwrites the register contents on the next clock edge.
- Used as a low-glitch sequencer and phase generator; the output decodes with 2-input gates.

---
 rtl/johnson_counter.sv | 44 ++++
 tb/tb_johnson_counter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/johnson_counter.sv
// W-bit Johnson (twisted-ring) counter with parallel seed load and optional
// one-cycle recovery from illegal states back to the all-zeros legal state.
module johnson_counter #(
    parameter int W            = 4,
    parameter bit SELF_CORRECT = 1'b1
) (
    input  logic         clock,
    input  logic         clear,
    input  logic [W-1:0] seq,
    output logic [W-1:0] dout
);

    localparam logic [W-2:0] ONE = (W-1)'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-2:0] bit_edges;
    logic         illegal;

    // A legal Johnson state has at most one boundary between adjacent bits,
    // so the adjacent-bit difference vector must be zero or one-hot.
    assign bit_edges = cnt_q[W-2:0] ^ cnt_q[W-1:1];
    assign illegal   = (bit_edges & (bit_edges - ONE)) != '0;

    always_comb begin
        cnt_d = {cnt_q[W-2:0], ~cnt_q[W-1]};
        if (seq != '0) begin
            cnt_d = seq;
        end else if (SELF_CORRECT && illegal) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign dout = cnt_q;

endmodule

// File: tb/tb_johnson_counter.sv
// Bench for johnson_counter: directed sequences, a width sweep and random
// load/clear traffic checked against a rule-level reference model.
module tb_johnson_counter;

    localparam int N = 5;

    logic        clock;
    logic        clear;
    logic [31:0] seq_v  [N];
    logic [31:0] dout_v [N];
    logic [31:0] m      [N];
    int          wid    [N];
    bit          scor   [N];
    int          n_checks;
    int          n_errors;

    logic [3:0] d4c, d4n;
    logic [1:0] d2;
    logic [4:0] d5;
    logic [7:0] d8;

    // u0: W=4 corrected, u1: W=4 uncorrected, u2/u3/u4: W=2/5/8 corrected
    johnson_counter #(.W(4), .SELF_CORRECT(1'b1)) u4c (
        .clock(clock), .clear(clear), .seq(seq_v[0][3:0]), .dout(d4c));
    johnson_counter #(.W(4), .SELF_CORRECT(1'b0)) u4n (
        .clock(clock), .clear(clear), .seq(seq_v[1][3:0]), .dout(d4n));
    johnson_counter #(.W(2), .SELF_CORRECT(1'b1)) u2 (
        .clock(clock), .clear(clear), .seq(seq_v[2][1:0]), .dout(d2));
    johnson_counter #(.W(5), .SELF_CORRECT(1'b1)) u5 (
        .clock(clock), .clear(clear), .seq(seq_v[3][4:0]), .dout(d5));
    johnson_counter #(.W(8), .SELF_CORRECT(1'b1)) u8 (
        .clock(clock), .clear(clear), .seq(seq_v[4][7:0]), .dout(d8));

    assign dout_v[0] = {28'b0, d4c};
    assign dout_v[1] = {28'b0, d4n};
    assign dout_v[2] = {30'b0, d2};
    assign dout_v[3] = {27'b0, d5};
    assign dout_v[4] = {24'b0, d8};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] mask_of(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic bit is_legal(input logic [31:0] v, input int w);
        int changes;
        changes = 0;
        for (int i = 0; i < w - 1; i++) begin
            if (v[i] != v[i+1]) changes++;
        end
        return changes <= 1;
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] v, input logic [31:0] s,
                                             input int w, input bit sc);
        logic [31:0] msb;
        if (s != 0) return s;
        if (sc && !is_legal(v, w)) return 0;
        msb = (v >> (w - 1)) & 32'd1;
        return ((v << 1) | (msb ^ 32'd1)) & mask_of(w);
    endfunction

    // Closed-form k-th state of the legal ring starting from zero.
    function automatic logic [31:0] ring_state(input int k, input int w);
        int p;
        p = k % (2 * w);
        if (p <= w) return (32'd1 << p) - 32'd1;
        return (mask_of(w) << (p - w)) & mask_of(w);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        for (int i = 0; i < N; i++) begin
            m[i] = clear ? ref_next(m[i], seq_v[i], wid[i], scor[i]) : 32'd0;
        end
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("model_u%0d", i), dout_v[i], m[i]);
        end
    endtask

    task automatic set_all_seq(input logic [31:0] v);
        for (int i = 0; i < N; i++) seq_v[i] = v & mask_of(wid[i]);
    endtask

    task automatic do_reset();
        clear = 1'b0;
        for (int i = 0; i < N; i++) m[i] = 0;
        step();
        clear = 1'b1;
    endtask

    logic [31:0] exp1 [11];
    logic [31:0] exp4c [8];
    logic [31:0] exp4n [8];
    logic [31:0] exp5 [3];

    initial begin
        n_checks = 0;
        n_errors = 0;
        wid  = '{4, 4, 2, 5, 8};
        scor = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        exp1  = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1, 4'h3};
        exp4c = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
        exp4n = '{4'hD, 4'hA, 4'h4, 4'h9, 4'h2, 4'h5, 4'hB, 4'h6};
        exp5  = '{4'h8, 4'h0, 4'h1};
        clear = 1'b0;
        set_all_seq(0);
        for (int i = 0; i < N; i++) m[i] = 0;
        #1;
        check("reset_async", dout_v[0], 32'd0);

        // Reset and count through the W=4 ring
        do_reset();
        #1;
        check("count_0", dout_v[0], exp1[0]);
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("count_%0d", k), dout_v[0], exp1[k]);
        end

        // Async clear between edges at 0111, held with a non-zero seq
        do_reset();
        for (int k = 0; k < 3; k++) step();
        check("pre_clear_0111", dout_v[0], 32'h7);
        #2;
        clear = 1'b0;
        for (int i = 0; i < N; i++) m[i] = 0;
        #1;
        check("async_clear", dout_v[0], 32'd0);
        seq_v[0] = 32'h5;
        for (int k = 0; k < 2; k++) begin
            step();
            check("clear_hold", dout_v[0], 32'd0);
        end
        seq_v[0] = 0;
        clear = 1'b1;

        // Illegal seed 0110, with and without correction
        do_reset();
        seq_v[0] = 32'h6;
        seq_v[1] = 32'h6;
        step();
        check("load_c", dout_v[0], 32'h6);
        check("load_n", dout_v[1], 32'h6);
        set_all_seq(0);
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("corr_%0d", k), dout_v[0], exp4c[k]);
            check($sformatf("ring_%0d", k), dout_v[1], exp4n[k]);
        end

        // Legal seed held for three edges
        seq_v[0] = 32'hC;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_1100", dout_v[0], 32'hC);
        end
        seq_v[0] = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("after_hold_%0d", k), dout_v[0], exp5[k]);
        end

        // Width sweep: period exactly 2*W, every state legal
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            step();
            for (int i = 2; i < N; i++) begin
                check($sformatf("sweep_w%0d_k%0d", wid[i], k), dout_v[i], ring_state(k, wid[i]));
                check($sformatf("legal_w%0d", wid[i]), 32'(is_legal(dout_v[i], wid[i])), 32'd1);
                if (k <= 2 * wid[i]) begin
                    check($sformatf("zero_w%0d_k%0d", wid[i], k),
                          32'(dout_v[i] == 0), 32'(k == 2 * wid[i]));
                end
            end
        end

        // Random loads and occasional clears
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N; i++) begin
                seq_v[i] = ($urandom_range(0, 3) == 0) ? ($urandom & mask_of(wid[i])) : 32'd0;
            end
            if ($urandom_range(0, 29) == 0) begin
                clear = 1'b0;
                for (int i = 0; i < N; i++) m[i] = 0;
                #1;
                check("rand_async_clear", dout_v[$urandom_range(0, N-1)], 32'd0);
            end else begin
                clear = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
